// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU package: small helpers used by several SPU operator stages.
package elixirchip_es1_spu_pkg;

    function automatic int spu_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay_rst.sv
// Clock-enabled shift register with synchronous active-low reset.
// A depth of 0 turns the block into a plain wire.
module elixirchip_es1_spu_delay_rst #(
    parameter int    DATA_BITS  = 1,
    parameter int    DEPTH      = 1,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] s_data,
    output logic [DATA_BITS-1:0] m_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, reset, cke};
            assign m_data = s_data;
        end else begin : g_pipe
            logic [DATA_BITS-1:0] pipe [DEPTH];

            // Reset takes priority over cke so a frozen pipeline can still be flushed.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe[i] <= '0;
                    end
                end else if (cke) begin
                    pipe[0] <= s_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign m_data = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/elixirchip_es1_spu_op_accu.sv
// Unsigned accumulator following the SPU multiplier: clear-or-add per sample,
// optional saturation, sticky overflow, output shift and extra latency.
module elixirchip_es1_spu_op_accu
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int    LATENCY      = 1,
    parameter int    S_DATA_BITS  = 16,
    parameter int    ACC_BITS     = 24,
    parameter int    M_DATA_BITS  = 16,
    parameter int    DATA_SHIFT   = 0,
    parameter bit    USE_SATURATE = 1'b0,
    parameter bit    USE_VALID    = 1'b0,
    parameter string DEVICE       = "RTL",
    parameter string SIMULATION   = "false",
    parameter string DEBUG        = "false"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  logic [S_DATA_BITS-1:0] s_data,
    input  logic                   s_clear,
    input  logic                   s_valid,
    output logic [M_DATA_BITS-1:0] m_data,
    output logic                   m_overflow
);

    typedef logic unsigned [ACC_BITS-1:0] acc_t;
    typedef logic unsigned [ACC_BITS:0]   sum_t;

    localparam int EXT_BITS = spu_max(ACC_BITS, M_DATA_BITS);

    acc_t acc;
    logic ovf;
    sum_t sum;
    logic update;

    assign update = cke && (s_valid || !USE_VALID);
    assign sum    = sum_t'(acc) + sum_t'(s_data);

    // Clear wins over a carry out of the same add.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (update) begin
            if (s_clear) begin
                acc <= acc_t'(s_data);
                ovf <= 1'b0;
            end else if (sum[ACC_BITS]) begin
                acc <= USE_SATURATE ? '1 : sum[ACC_BITS-1:0];
                ovf <= 1'b1;
            end else begin
                acc <= sum[ACC_BITS-1:0];
            end
        end
    end

    logic [EXT_BITS-1:0]    acc_ext;
    logic [M_DATA_BITS-1:0] fmt_data;

    assign acc_ext  = EXT_BITS'(acc);
    assign fmt_data = M_DATA_BITS'(acc_ext >> DATA_SHIFT);

    elixirchip_es1_spu_delay_rst #(
        .DATA_BITS  (M_DATA_BITS + 1),
        .DEPTH      (LATENCY - 1),
        .DEVICE     (DEVICE),
        .SIMULATION (SIMULATION),
        .DEBUG      (DEBUG)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .cke    (cke),
        .s_data ({fmt_data, ovf}),
        .m_data ({m_data, m_overflow})
    );

endmodule

// File: tb/tb_elixirchip_es1_spu_op_accu.sv
// Directed bench for elixirchip_es1_spu_op_accu across four configurations
// that share one stimulus stream.
module tb_elixirchip_es1_spu_op_accu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cke = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_clear = 1'b0;
    logic        s_valid = 1'b0;

    logic [15:0] basic_data, wrap_data, sat_data;
    logic [7:0]  lat_data;
    logic        basic_ovf, wrap_ovf, sat_ovf, lat_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_accu #(
        .LATENCY(1), .S_DATA_BITS(16), .ACC_BITS(24), .M_DATA_BITS(16),
        .DATA_SHIFT(0), .USE_SATURATE(1'b0), .USE_VALID(1'b1)
    ) u_basic (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(basic_data), .m_overflow(basic_ovf)
    );

    elixirchip_es1_spu_op_accu #(
        .LATENCY(1), .S_DATA_BITS(16), .ACC_BITS(16), .M_DATA_BITS(16),
        .DATA_SHIFT(0), .USE_SATURATE(1'b0), .USE_VALID(1'b1)
    ) u_wrap (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(wrap_data), .m_overflow(wrap_ovf)
    );

    elixirchip_es1_spu_op_accu #(
        .LATENCY(1), .S_DATA_BITS(16), .ACC_BITS(16), .M_DATA_BITS(16),
        .DATA_SHIFT(0), .USE_SATURATE(1'b1), .USE_VALID(1'b1)
    ) u_sat (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(sat_data), .m_overflow(sat_ovf)
    );

    elixirchip_es1_spu_op_accu #(
        .LATENCY(4), .S_DATA_BITS(16), .ACC_BITS(24), .M_DATA_BITS(8),
        .DATA_SHIFT(4), .USE_SATURATE(1'b0), .USE_VALID(1'b1)
    ) u_lat (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear),
        .s_valid(s_valid), .m_data(lat_data), .m_overflow(lat_ovf)
    );

    // Drive on the falling edge, let one rising edge pass, then settle 1 time unit.
    task automatic cycle(input logic rst_n, input logic k, input logic [15:0] d,
                         input logic c, input logic v);
        @(negedge clk);
        reset   = rst_n;
        cke     = k;
        s_data  = d;
        s_clear = c;
        s_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with cke low must still clear everything.
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        check("reset_basic_data", 32'(basic_data), 32'h0);
        check("reset_basic_ovf",  32'(basic_ovf),  32'h0);
        check("reset_lat_data",   32'(lat_data),   32'h0);
        check("reset_lat_ovf",    32'(lat_ovf),    32'h0);

        // Basic sum 3, 5, 7.
        cycle(1'b1, 1'b1, 16'd3, 1'b1, 1'b1);
        check("basic_s1", 32'(basic_data), 32'd3);
        cycle(1'b1, 1'b1, 16'd5, 1'b0, 1'b1);
        check("basic_s2", 32'(basic_data), 32'd8);
        cycle(1'b1, 1'b1, 16'd7, 1'b0, 1'b1);
        check("basic_s3", 32'(basic_data), 32'd15);
        check("basic_ovf", 32'(basic_ovf), 32'h0);

        // Valid gap and cke freeze.
        cycle(1'b1, 1'b1, 16'd3, 1'b1, 1'b1);
        check("gate_s1", 32'(basic_data), 32'd3);
        cycle(1'b1, 1'b1, 16'd5, 1'b0, 1'b1);
        check("gate_s2", 32'(basic_data), 32'd8);
        cycle(1'b1, 1'b1, 16'd9, 1'b0, 1'b0);
        check("gate_invalid", 32'(basic_data), 32'd8);
        cycle(1'b1, 1'b0, 16'd9, 1'b0, 1'b1);
        check("gate_cke0_a", 32'(basic_data), 32'd8);
        cycle(1'b1, 1'b0, 16'd9, 1'b1, 1'b1);
        check("gate_cke0_b", 32'(basic_data), 32'd8);
        cycle(1'b1, 1'b1, 16'd7, 1'b0, 1'b1);
        check("gate_final", 32'(basic_data), 32'd15);

        // Wrap versus saturate on 16-bit accumulators.
        cycle(1'b1, 1'b1, 16'hFFF0, 1'b1, 1'b1);
        check("wrap_start", 32'(wrap_data), 32'hFFF0);
        check("sat_start",  32'(sat_data),  32'hFFF0);
        check("sat_start_ovf", 32'(sat_ovf), 32'h0);
        cycle(1'b1, 1'b1, 16'h0020, 1'b0, 1'b1);
        check("wrap_data", 32'(wrap_data), 32'h0010);
        check("wrap_ovf",  32'(wrap_ovf),  32'h1);
        check("sat_data1", 32'(sat_data),  32'hFFFF);
        check("sat_ovf1",  32'(sat_ovf),   32'h1);
        cycle(1'b1, 1'b1, 16'h0001, 1'b0, 1'b1);
        check("sat_data2", 32'(sat_data),  32'hFFFF);
        check("sat_ovf2",  32'(sat_ovf),   32'h1);
        check("wrap_sticky_data", 32'(wrap_data), 32'h0011);
        check("wrap_sticky_ovf",  32'(wrap_ovf),  32'h1);
        cycle(1'b1, 1'b1, 16'h0001, 1'b1, 1'b1);
        check("wrap_clear_data", 32'(wrap_data), 32'h1);
        check("wrap_clear_ovf",  32'(wrap_ovf),  32'h0);
        check("sat_clear_data",  32'(sat_data),  32'h1);
        check("sat_clear_ovf",   32'(sat_ovf),   32'h0);

        // Clear colliding with a would-be overflow.
        cycle(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 16'h0002, 1'b0, 1'b1);
        check("wrap_ovf_again", 32'(wrap_ovf), 32'h1);
        cycle(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        check("clear_wins_data", 32'(wrap_data), 32'hFFFF);
        check("clear_wins_ovf",  32'(wrap_ovf),  32'h0);

        // Shift and latency: flush first so the delay line is known-zero.
        cycle(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0100, 1'b1, 1'b1);
        check("lat_e1", 32'(lat_data), 32'h0);
        cycle(1'b1, 1'b1, 16'h0100, 1'b0, 1'b1);
        check("lat_e2", 32'(lat_data), 32'h0);
        cycle(1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        check("lat_e3", 32'(lat_data), 32'h0);
        cycle(1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        check("lat_e4", 32'(lat_data), 32'h10);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        check("lat_frozen", 32'(lat_data), 32'h10);
        cycle(1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        check("lat_e5", 32'(lat_data), 32'h20);
        check("lat_ovf", 32'(lat_ovf), 32'h0);

        // Reset mid-accumulation discards the partial sum.
        cycle(1'b1, 1'b1, 16'd10, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 16'd20, 1'b0, 1'b1);
        check("rst_pre", 32'(basic_data), 32'd30);
        cycle(1'b0, 1'b1, 16'd0, 1'b0, 1'b0);
        check("rst_mid_data", 32'(basic_data), 32'd0);
        cycle(1'b1, 1'b1, 16'd5, 1'b0, 1'b1);
        check("rst_post_data", 32'(basic_data), 32'd5);
        check("rst_post_ovf",  32'(basic_ovf),  32'h0);

        // Reset while cke is low still clears stage 0 and the delay line.
        cycle(1'b1, 1'b1, 16'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'd0, 1'b0, 1'b0);
        check("lat_before_rst", 32'(lat_data), 32'h0);
        cycle(1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        check("rst_cke0_basic", 32'(basic_data), 32'd0);
        check("rst_cke0_wrap",  32'(wrap_data),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
